// File: rtl/alu_pkg.sv
// Shared ALU package.
// Holds the default operand widths used by both the multiplier and the
// divider, the sequencer state encoding, and a small width helper.
//   DEF_N     : default divisor / remainder width
//   DEF_M     : default quotient width (and divider iteration count)
//   state_t   : IDLE / RUN / FIN sequencer states
//   cnt_width : bits needed to count down from m-1 to 0 (at least 1)
package alu_pkg;

  localparam int DEF_N = 3;
  localparam int DEF_M = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIN  = 2'd2
  } state_t;

  function automatic int cnt_width(input int m);
    return (m > 1) ? $clog2(m) : 1;
  endfunction

endpackage

// File: rtl/div_step.sv
// One restoring-division step: conditionally subtracts the divisor from the
// shifted partial remainder. The subtraction is rem + ~{0,den} + 1 through a
// ripple chain of full_adder cells; a carry out of the top means no borrow.
// Ports:
//   rem      : shifted partial remainder {R[N-1:0], next dividend bit}, N+1 bits
//   den      : divisor, N bits
//   rem_next : next partial remainder, N bits
//   q_bit    : quotient bit produced by this step (1 = subtraction kept)
module div_step #(
  parameter int N = 3
) (
  input  logic [N:0]   rem,
  input  logic [N-1:0] den,
  output logic [N-1:0] rem_next,
  output logic         q_bit
);

  logic [N-1:0] den_n;
  logic [N:0]   carry;
  logic [N-1:0] diff;

  assign den_n    = ~den;
  assign carry[0] = 1'b1;

  for (genvar i = 0; i < N; i++) begin : g_cell
    full_adder u_fa (
      .a   (rem[i]),
      .b   (den_n[i]),
      .cin (carry[i]),
      .sum (diff[i]),
      .cout(carry[i+1])
    );
  end

  // The top cell adds rem[N] to the inverted zero-extension bit (always 1),
  // so its carry out reduces to rem[N] | carry[N]; its sum bit is never needed
  // because a kept difference is always below the divisor.
  assign q_bit    = rem[N] | carry[N];
  assign rem_next = q_bit ? diff : rem[N-1:0];

endmodule

// File: rtl/full_adder.sv
// One-bit full adder cell shared by the ALU arithmetic blocks.
// Ports:
//   a, b : operand bits
//   cin  : carry in
//   sum  : sum bit
//   cout : carry out
module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);

  assign sum  = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/divide_seq.sv
// Sequential restoring divider, one quotient bit per clock.
// Divides an (N+M)-bit dividend by an N-bit divisor giving an M-bit quotient
// and an N-bit remainder, with divide-by-zero and quotient-overflow detected
// up front so those cases finish without iterating.
// Ports:
//   clk, rst_n : clock and synchronous active-low reset
//   start      : request a division (taken only while idle)
//   dividend   : N+M-bit numerator, sampled on the accepting edge
//   divisor    : N-bit denominator, sampled on the accepting edge
//   busy       : operation in progress
//   done       : one-cycle pulse when results update
//   quotient   : M-bit result quotient
//   remainder  : N-bit result remainder
//   div_zero   : last operation had a zero divisor
//   overflow   : last quotient did not fit in M bits
module divide_seq
  import alu_pkg::*;
#(
  parameter int N = DEF_N,
  parameter int M = DEF_M
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           start,
  input  logic [N+M-1:0] dividend,
  input  logic [N-1:0]   divisor,
  output logic           busy,
  output logic           done,
  output logic [M-1:0]   quotient,
  output logic [N-1:0]   remainder,
  output logic           div_zero,
  output logic           overflow
);

  localparam int CW = cnt_width(M);

  state_t         state;
  state_t         state_next;
  logic [N-1:0]   d;
  logic [N-1:0]   r;
  logic [M-1:0]   q;
  logic [CW-1:0]  cnt;
  logic           dz_pend;
  logic           ov_pend;
  logic [N-1:0]   r_step;
  logic           q_bit;
  logic [N-1:0]   dividend_hi;
  logic           zero_div;
  logic           early_ovf;

  // The partial remainder stays below the divisor, so N bits of storage are
  // enough; the extra step bit comes from the dividend bit shifted in.
  div_step #(.N(N)) u_step (
    .rem     ({r, q[M-1]}),
    .den     (d),
    .rem_next(r_step),
    .q_bit   (q_bit)
  );

  assign dividend_hi = dividend[N+M-1:M];
  assign busy        = (state != IDLE);

  // Early-exit checks: a quotient fits in M bits only if the upper part of
  // the dividend is already smaller than the divisor.
  always_comb begin
    zero_div  = (divisor == '0);
    early_ovf = !zero_div && (dividend_hi >= divisor);
  end

  // Next-state logic; the early exits skip RUN entirely.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (start) state_next = (zero_div || early_ovf) ? FIN : RUN;
      RUN:  if (cnt == '0) state_next = FIN;
      FIN:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Datapath and result registers. Early exits preload q/r with their fixed
  // results so FIN handles every path the same way.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      done      <= 1'b0;
      quotient  <= '0;
      remainder <= '0;
      div_zero  <= 1'b0;
      overflow  <= 1'b0;
      d         <= '0;
      r         <= '0;
      q         <= '0;
      cnt       <= '0;
      dz_pend   <= 1'b0;
      ov_pend   <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            d   <= divisor;
            cnt <= CW'(M - 1);
            if (zero_div) begin
              q       <= '1;
              r       <= dividend[N-1:0];
              dz_pend <= 1'b1;
              ov_pend <= 1'b0;
            end else if (early_ovf) begin
              q       <= '1;
              r       <= '0;
              dz_pend <= 1'b0;
              ov_pend <= 1'b1;
            end else begin
              q       <= dividend[M-1:0];
              r       <= dividend_hi;
              dz_pend <= 1'b0;
              ov_pend <= 1'b0;
            end
          end
        end
        RUN: begin
          r   <= r_step;
          q   <= M'({q, q_bit});
          cnt <= cnt - CW'(1);
        end
        FIN: begin
          quotient  <= q;
          remainder <= r;
          div_zero  <= dz_pend;
          overflow  <= ov_pend;
          done      <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_divide_seq.sv
// Self-checking bench for divide_seq (N=3, M=8): directed vector table,
// multi-cycle corner sequences, and random operands against a reference.
module tb_divide_seq;

  localparam int N = 3;
  localparam int M = 8;

  logic           clk = 1'b0;
  logic           rst_n;
  logic           start;
  logic [N+M-1:0] dividend;
  logic [N-1:0]   divisor;
  logic           busy;
  logic           done;
  logic [M-1:0]   quotient;
  logic [N-1:0]   remainder;
  logic           div_zero;
  logic           overflow;

  int nCompared   = 0;
  int nMismatched = 0;

  typedef struct {
    logic [N+M-1:0] dd;
    logic [N-1:0]   dv;
    logic [M-1:0]   q;
    logic [N-1:0]   r;
    logic           dz;
    logic           ov;
    int             lat;
  } vec_t;

  localparam int NV = 11;
  vec_t vecs [NV];

  divide_seq #(.N(N), .M(M)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .dividend (dividend),
    .divisor  (divisor),
    .busy     (busy),
    .done     (done),
    .quotient (quotient),
    .remainder(remainder),
    .div_zero (div_zero),
    .overflow (overflow)
  );

  always #5 clk = ~clk;

  // Compare one value and keep the counters.
  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    nCompared++;
    if (act !== exp) begin
      nMismatched++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Present a request and return just after the accepting edge.
  task automatic applyStimulus(input logic [N+M-1:0] dd, input logic [N-1:0] dv);
    start    = 1'b1;
    dividend = dd;
    divisor  = dv;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  // Wait for done with a bounded budget; cyc is the spec's cycle offset
  // from the accepting edge (edges waited + 1).
  task automatic waitDone(output int cyc);
    bit found = 0;
    cyc = 0;
    for (int i = 1; i <= 40 && !found; i++) begin
      @(posedge clk);
      #1;
      if (done) begin
        cyc   = i + 1;
        found = 1;
      end
    end
    checkOutput("done_seen", 32'(found), 32'd1);
  endtask

  task automatic checkResult(input string tag, input logic [M-1:0] q, input logic [N-1:0] r,
                             input logic dz, input logic ov);
    checkOutput({tag, "_quotient"}, 32'(quotient), 32'(q));
    checkOutput({tag, "_remainder"}, 32'(remainder), 32'(r));
    checkOutput({tag, "_div_zero"}, 32'(div_zero), 32'(dz));
    checkOutput({tag, "_overflow"}, 32'(overflow), 32'(ov));
  endtask

  initial begin
    int cyc;
    int doneCount;
    logic [N+M-1:0] rdd;
    logic [N-1:0]   rdv;
    logic [M-1:0]   eq;
    logic [N-1:0]   er;
    logic           edz;
    logic           eov;

    vecs[0]  = '{11'd100,  3'd7, 8'd14,  3'd2, 1'b0, 1'b0, 10};
    vecs[1]  = '{11'd1791, 3'd7, 8'd255, 3'd6, 1'b0, 1'b0, 10};
    vecs[2]  = '{11'd0,    3'd5, 8'd0,   3'd0, 1'b0, 1'b0, 10};
    vecs[3]  = '{11'd100,  3'd0, 8'd255, 3'd4, 1'b1, 1'b0, 2};
    vecs[4]  = '{11'd2047, 3'd7, 8'd255, 3'd0, 1'b0, 1'b1, 2};
    vecs[5]  = '{11'd1000, 3'd5, 8'd200, 3'd0, 1'b0, 1'b0, 10};
    vecs[6]  = '{11'd500,  3'd3, 8'd166, 3'd2, 1'b0, 1'b0, 10};
    vecs[7]  = '{11'd255,  3'd1, 8'd255, 3'd0, 1'b0, 1'b0, 10};
    vecs[8]  = '{11'd256,  3'd1, 8'd255, 3'd0, 1'b0, 1'b1, 2};
    vecs[9]  = '{11'd1535, 3'd6, 8'd255, 3'd5, 1'b0, 1'b0, 10};
    vecs[10] = '{11'd7,    3'd7, 8'd1,   3'd0, 1'b0, 1'b0, 10};

    rst_n    = 1'b0;
    start    = 1'b0;
    dividend = '0;
    divisor  = '0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset_busy", 32'(busy), 32'd0);
    checkOutput("reset_done", 32'(done), 32'd0);
    checkResult("reset", '0, '0, 1'b0, 1'b0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    $display("[TB] directed vectors");
    for (int i = 0; i < NV; i++) begin
      applyStimulus(vecs[i].dd, vecs[i].dv);
      checkOutput("busy_after_start", 32'(busy), 32'd1);
      waitDone(cyc);
      checkOutput("latency", 32'(cyc), 32'(vecs[i].lat));
      checkResult("vec", vecs[i].q, vecs[i].r, vecs[i].dz, vecs[i].ov);
      @(posedge clk);
      #1;
      checkOutput("done_one_cycle", 32'(done), 32'd0);
      checkOutput("idle_after_done", 32'(busy), 32'd0);
    end

    $display("[TB] start pulsed during RUN");
    applyStimulus(11'd100, 3'd7);
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    start    = 1'b1;
    dividend = 11'd2047;
    divisor  = 3'd7;
    @(posedge clk);
    #1;
    start = 1'b0;
    waitDone(cyc);
    checkOutput("ignored_start_latency", 32'(cyc), 32'd6);
    checkResult("ignored_start", 8'd14, 3'd2, 1'b0, 1'b0);

    $display("[TB] back-to-back start in done cycle");
    applyStimulus(11'd1000, 3'd5);
    checkOutput("b2b_busy", 32'(busy), 32'd1);
    checkOutput("b2b_hold_quotient", 32'(quotient), 32'd14);
    waitDone(cyc);
    checkOutput("b2b_latency", 32'(cyc), 32'd10);
    checkResult("b2b", 8'd200, 3'd0, 1'b0, 1'b0);
    @(posedge clk);
    #1;

    $display("[TB] reset during RUN step 4");
    applyStimulus(11'd1791, 3'd7);
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    checkOutput("midreset_busy", 32'(busy), 32'd0);
    checkOutput("midreset_done", 32'(done), 32'd0);
    checkResult("midreset", '0, '0, 1'b0, 1'b0);
    rst_n     = 1'b1;
    doneCount = 0;
    for (int i = 0; i < 15; i++) begin
      @(posedge clk);
      #1;
      if (done) doneCount++;
    end
    checkOutput("midreset_no_done", 32'(doneCount), 32'd0);

    $display("[TB] random operands");
    for (int i = 0; i < 1000; i++) begin
      rdd = 11'($urandom_range(0, 2047));
      rdv = 3'($urandom_range(0, 7));
      if (rdv == 0) begin
        eq = '1; er = rdd[N-1:0]; edz = 1'b1; eov = 1'b0;
      end else if ((rdd >> M) >= 11'(rdv)) begin
        eq = '1; er = '0; edz = 1'b0; eov = 1'b1;
      end else begin
        eq = 8'(rdd / 11'(rdv)); er = 3'(rdd % 11'(rdv)); edz = 1'b0; eov = 1'b0;
      end
      applyStimulus(rdd, rdv);
      waitDone(cyc);
      checkResult("rand", eq, er, edz, eov);
      if (!edz && !eov) begin
        checkOutput("rand_invariant", 32'(quotient) * 32'(rdv) + 32'(remainder), 32'(rdd));
        checkOutput("rand_rem_lt_div", 32'(remainder < rdv), 32'd1);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule

// File: doc/divide_seq.md
Name: divide_seq

Overview:
- Sequential restoring divider; the inverse of the combinational multiplier block in the arithmetic unit.
- Takes an (N+M)-bit dividend (a product-width value) and an N-bit divisor, and returns an M-bit quotient plus an N-bit remainder.
- Computes one quotient bit per clock.
- Sits beside the adder and multiplier in the ALU; the ALU control issues operations to it through a start/busy/done handshake.

Parameters:
- N, default 3: divisor and remainder width in bits.
- M, default 8: quotient width in bits, and the number of iteration cycles.

Ports:
- clk  input  1  single clock; every register updates on the rising edge.
- rst_n  input  1  synchronous active-low reset, sampled on the rising edge of clk.
- start  input  1  request a division; accepted only while busy=0.
- dividend  input  N+M  numerator, sampled on the accepting edge.
- divisor  input  N  denominator, sampled on the accepting edge.
- busy  output  1  high while an operation is in progress.
- done  output  1  one-cycle pulse when the result registers become valid.
- quotient  output  M  result quotient.
- remainder  output  N  result remainder.
- div_zero  output  1  the last operation had divisor == 0.
- overflow  output  1  the true quotient does not fit in M bits.

Behaviour:
- Clocking and reset: one clock, clk. Reset rst_n is synchronous and active-low.
- rst_n=0 at a rising edge forces state IDLE and clears busy, done, quotient, remainder, div_zero and overflow to 0. This holds mid-operation too; the in-flight division is discarded and produces no done.
- States:
  - IDLE: busy=0.
  - RUN: busy=1.
  - FIN: busy=1, lasts one cycle.
- IDLE -> RUN: start=1 at edge k.
  - Latch divisor into D.
  - Load partial remainder R (N+1 bits) with dividend[N+M-1:M].
  - Load shift register Q with dividend[M-1:0].
  - Clear iteration counter to M-1.
  - Evaluate the early-exit checks below on the same edge.
- Divide-by-zero (divisor==0): go IDLE -> FIN directly.
  - Result: quotient = all ones, remainder = dividend[N-1:0], div_zero=1, overflow=0.
- Overflow (divisor!=0 and dividend[N+M-1:M] >= divisor): go IDLE -> FIN directly.
  - Result: quotient = all ones, remainder = 0, overflow=1, div_zero=0.
- RUN, one step per edge:
  - T = {R[N-1:0], Q[M-1]} minus {1'b0, D}.
  - If T is non-negative (no borrow): R <= T[N-1:0] and the quotient bit is 1.
  - Otherwise: R keeps the shifted value and the quotient bit is 0.
  - Q shifts left with the quotient bit entering at Q[0].
  - The counter decrements. After M steps the block moves to FIN.
- FIN -> IDLE, one edge:
  - quotient <= Q, remainder <= R[N-1:0]; flags are registered as computed.
  - done=1 for exactly the cycle after this edge.
- Latency:
  - Normal path: start accepted at edge k, busy high in cycles k+1 .. k+M+1, done high in cycle k+M+2.
  - Early exits: done high in cycle k+2.
- start while busy=1 is ignored; there is no queueing.
- start asserted in the same cycle done is high is accepted, because the state is IDLE.
- quotient, remainder and flags hold their values until the next completion or reset, including during a following operation.
- Invariant when div_zero=0 and overflow=0: quotient*divisor + remainder == dividend, and remainder < divisor.
- All arithmetic is unsigned. No combinational path exists from any input to any output.

Decomposition:
- Shared package (alu_pkg): state encoding constants IDLE/RUN/FIN and the default N/M values, so the multiplier and divider share widths.
- One sub-module, div_step: the combinational N+1-bit conditional subtract (inputs R, D; outputs the next R and the quotient bit), built from the existing full_adder cells in a ripple borrow chain.
- divide_seq contains only the FSM, the counter and the registers.

Test Plan:
- Basic: dividend=100, divisor=7 -> done after 10 cycles; quotient=14, remainder=2, flags 0.
- Max valid: dividend=1791, divisor=7 -> quotient=255, remainder=6.
- Zero dividend: dividend=0, divisor=5 -> quotient=0, remainder=0.
- Divide-by-zero: dividend=100, divisor=0 -> done in cycle k+2; div_zero=1, quotient=255, remainder=4.
- Overflow: dividend=2047, divisor=7 -> done in cycle k+2; overflow=1, quotient=255, remainder=0.
- Robustness, in one run:
  - start pulsed again during RUN -> ignored; the first result is unchanged.
  - rst_n=0 at RUN step 4 -> all outputs 0, no done pulse.
  - A back-to-back start during the done cycle is accepted.
- Random: 1000 random operand pairs checked against a reference model using the invariant above.
